// File: rtl/jacobian_to_affine_pkg.sv
// -----------------------------------------------------------------------------
// jacobian_to_affine_pkg
// Shared definitions for the Jacobian-to-affine converter:
//   N        - operand / modulus width in bits
//   P        - secp256k1 field prime
//   GX, GY   - secp256k1 generator point (affine)
//   state_t  - converter control states
//   inv_op_t - the single operation chosen for one modular-inverse cycle
// -----------------------------------------------------------------------------
package jacobian_to_affine_pkg;

    localparam int N = 256;

    localparam logic [N-1:0] P  =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [N-1:0] GX =
        256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
    localparam logic [N-1:0] GY =
        256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        INV,
        MUL_Z2,
        MUL_Z3,
        MUL_X,
        MUL_Y,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        INV_FINISH,   // u or v reached 1: inverse is known
        INV_HALVE_U,
        INV_HALVE_V,
        INV_SUB_U,    // u -= v, x1 -= x2
        INV_SUB_V     // v -= u, x2 -= x1
    } inv_op_t;

endpackage

// File: rtl/mod_mul_serial.sv
// -----------------------------------------------------------------------------
// mod_mul_serial
// Bit-serial modular multiplier r = a*b mod m, MSB-first interleaved:
// each cycle acc = 2*acc mod m, then acc = acc + a mod m if the current bit
// of b is set. Operands are captured on start; done pulses exactly N+2
// cycles after start and r holds its value until the next result.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start         - one-cycle request; captures a, b, m
//   a, b, m       - operands (a < m required), modulus
//   r             - product, fully reduced
//   done          - one-cycle pulse when r is updated
// -----------------------------------------------------------------------------
module mod_mul_serial #(
    parameter int N = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] m,
    output logic [N-1:0] r,
    output logic         done
);

    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [N-1:0]  m_q;
    logic [N-1:0]  acc_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;

    logic [N:0]    dbl;
    logic [N-1:0]  dbl_red;
    logic [N:0]    sum;
    logic [N-1:0]  acc_step;

    // One interleaved step; N+1 bits hold 2*acc and acc+a without overflow.
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        dbl      = {acc_q, 1'b0};
        dbl_red  = dbl[N-1:0];
        sum      = '0;
        acc_step = '0;
        if (dbl >= {1'b0, m_q}) begin
            dbl     = dbl - {1'b0, m_q};
            dbl_red = dbl[N-1:0];
        end
        acc_step = dbl_red;
        if (b_q[N-1]) begin
            sum = {1'b0, dbl_red} + {1'b0, a_q};
            if (sum >= {1'b0, m_q}) begin
                sum = sum - {1'b0, m_q};
            end
            acc_step = sum[N-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            r      <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_q    <= a;
                b_q    <= b;
                m_q    <= m;
                acc_q  <= '0;
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                // N bit steps, then one cycle to publish the result.
                if (cnt_q == CW'(N)) begin
                    r      <= acc_q;
                    done   <= 1'b1;
                    busy_q <= 1'b0;
                end else begin
                    acc_q <= acc_step;
                    b_q   <= b_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/jacobian_to_affine.sv
// -----------------------------------------------------------------------------
// jacobian_to_affine
// Converts a Jacobian point (X, Y, Z) over GF(m) to affine form
// x = X*Z^-2, y = Y*Z^-3 (mod m). Z^-1 comes from a binary extended-Euclid
// loop (one operation per cycle), followed by four products on one shared
// bit-serial multiplier. Z = 0 reports the point at infinity.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - request; accepted only in IDLE or DONE
//   px, py, pz      - Jacobian coordinates (each < m)
//   m               - odd prime modulus
//   ax, ay          - affine result, fully reduced
//   inf             - result is the point at infinity
//   ready           - result valid; held in DONE until the next start
// -----------------------------------------------------------------------------
module jacobian_to_affine #(
    parameter int N = jacobian_to_affine_pkg::N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] px,
    input  logic [N-1:0] py,
    input  logic [N-1:0] pz,
    input  logic [N-1:0] m,
    output logic [N-1:0] ax,
    output logic [N-1:0] ay,
    output logic         inf,
    output logic         ready
);

    import jacobian_to_affine_pkg::*;

    state_t       state_q, state_d;
    inv_op_t      inv_op;

    logic [N-1:0] px_q, py_q, pz_q, m_q;
    logic [N-1:0] u_q, v_q, x1_q, x2_q;
    logic [N-1:0] zi_q, t2_q, t3_q;
    logic         mul_pending_q;

    logic         mul_start;
    logic [N-1:0] mul_a, mul_b, mul_r;
    logic         mul_done;
    logic         mul_capture;

    // x/2 mod m for odd m: an odd x is made even by adding m (N+1 bits).
    function automatic logic [N-1:0] half_mod(input logic [N-1:0] x,
                                              input logic [N-1:0] md);
        logic [N:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, md}) : {1'b0, x};
        return s[N:1];
    endfunction

    // a - b mod m for a, b < m; the wrap of N-bit arithmetic cancels when m
    // is added back after a borrow.
    function automatic logic [N-1:0] sub_mod(input logic [N-1:0] a,
                                             input logic [N-1:0] b,
                                             input logic [N-1:0] md);
        return (a >= b) ? (a - b) : (a - b + md);
    endfunction

    mod_mul_serial #(.N(N)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .m     (m_q),
        .r     (mul_r),
        .done  (mul_done)
    );

    // Choose the single inverse operation for this cycle, highest priority first.
    always_comb begin
        inv_op = INV_FINISH;
        if (u_q == N'(1) || v_q == N'(1)) begin
            inv_op = INV_FINISH;
        end else if (!u_q[0]) begin
            inv_op = INV_HALVE_U;
        end else if (!v_q[0]) begin
            inv_op = INV_HALVE_V;
        end else if (u_q >= v_q) begin
            inv_op = INV_SUB_U;
        end else begin
            inv_op = INV_SUB_V;
        end
    end

    // Multiplier operand select; operands are captured by the multiplier on
    // mul_start, so the mux only matters in that cycle.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (state_q)
            MUL_Z2:  begin mul_a = zi_q; mul_b = zi_q; end
            MUL_Z3:  begin mul_a = t2_q; mul_b = zi_q; end
            MUL_X:   begin mul_a = px_q; mul_b = t2_q; end
            MUL_Y:   begin mul_a = py_q; mul_b = t3_q; end
            default: begin mul_a = '0;   mul_b = '0;   end
        endcase
    end

    // Each multiply state issues start once, then waits for the product.
    assign mul_capture = mul_pending_q && mul_done;

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) state_d = CHECK;
            end
            CHECK: begin
                state_d = (pz_q == '0) ? DONE : INV;
            end
            INV: begin
                if (inv_op == INV_FINISH) state_d = MUL_Z2;
            end
            MUL_Z2: begin
                mul_start = !mul_pending_q;
                if (mul_capture) state_d = MUL_Z3;
            end
            MUL_Z3: begin
                mul_start = !mul_pending_q;
                if (mul_capture) state_d = MUL_X;
            end
            MUL_X: begin
                mul_start = !mul_pending_q;
                if (mul_capture) state_d = MUL_Y;
            end
            MUL_Y: begin
                mul_start = !mul_pending_q;
                if (mul_capture) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the wide datapath registers are cleared too, so an aborted
            // conversion leaves nothing behind that a later one could observe.
            state_q       <= IDLE;
            px_q          <= '0;
            py_q          <= '0;
            pz_q          <= '0;
            m_q           <= '0;
            u_q           <= '0;
            v_q           <= '0;
            x1_q          <= '0;
            x2_q          <= '0;
            zi_q          <= '0;
            t2_q          <= '0;
            t3_q          <= '0;
            mul_pending_q <= 1'b0;
            ax            <= '0;
            ay            <= '0;
            inf           <= 1'b0;
            ready         <= 1'b0;
        end else begin
            state_q <= state_d;

            if (mul_start) mul_pending_q <= 1'b1;
            if (mul_capture) mul_pending_q <= 1'b0;

            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        px_q  <= px;
                        py_q  <= py;
                        pz_q  <= pz;
                        m_q   <= m;
                        ready <= 1'b0;
                    end
                end
                CHECK: begin
                    if (pz_q == '0) begin
                        ax    <= '0;
                        ay    <= '0;
                        inf   <= 1'b1;
                        ready <= 1'b1;
                    end else begin
                        inf  <= 1'b0;
                        u_q  <= pz_q;
                        v_q  <= m_q;
                        x1_q <= N'(1);
                        x2_q <= '0;
                    end
                end
                INV: begin
                    unique case (inv_op)
                        INV_FINISH:  zi_q <= (u_q == N'(1)) ? x1_q : x2_q;
                        INV_HALVE_U: begin
                            u_q  <= u_q >> 1;
                            x1_q <= half_mod(x1_q, m_q);
                        end
                        INV_HALVE_V: begin
                            v_q  <= v_q >> 1;
                            x2_q <= half_mod(x2_q, m_q);
                        end
                        INV_SUB_U: begin
                            u_q  <= u_q - v_q;
                            x1_q <= sub_mod(x1_q, x2_q, m_q);
                        end
                        INV_SUB_V: begin
                            v_q  <= v_q - u_q;
                            x2_q <= sub_mod(x2_q, x1_q, m_q);
                        end
                        default: zi_q <= zi_q;
                    endcase
                end
                MUL_Z2: if (mul_capture) t2_q <= mul_r;
                MUL_Z3: if (mul_capture) t3_q <= mul_r;
                MUL_X:  if (mul_capture) ax   <= mul_r;
                MUL_Y: begin
                    if (mul_capture) begin
                        ay    <= mul_r;
                        ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
